// File: rtl/axi_read_arbiter.sv
// Two-master, single-outstanding AXI read-address arbiter with a fixed three-way address decode.
// Grants round-robin, routes AR to S0/S1 and answers unmapped reads with a one-beat DECERR.
module axi_read_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid_m0,
    input  logic        arvalid_m1,
    input  logic [31:0] araddr_m0,
    input  logic [31:0] araddr_m1,
    input  logic        arready_s0,
    input  logic        arready_s1,
    input  logic        rlast_hs,
    input  logic        rready_m0,
    input  logic        rready_m1,
    output logic        arready_m0,
    output logic        arready_m1,
    output logic        arvalid_s0_en,
    output logic        arvalid_s1_en,
    output logic [1:0]  grant,
    output logic [1:0]  slave_sel,
    output logic        def_rvalid,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDef
    } state_e;

    localparam logic [1:0] SelS0   = 2'd0;
    localparam logic [1:0] SelS1   = 2'd1;
    localparam logic [1:0] SelDef  = 2'd2;
    localparam logic [1:0] SelNone = 2'd3;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantM0   = 2'b01;
    localparam logic [1:0] GrantM1   = 2'b10;

    // S0 and S1 together occupy the low 128 KiB; bit 16 picks between them.
    function automatic logic [1:0] decode_addr(input logic [31:0] addr);
        if (addr[31:17] == 15'd0) begin
            return addr[16] ? SelS1 : SelS0;
        end
        return SelDef;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  sel_q, sel_d;
    logic        last_m1_q, last_m1_d;

    logic        any_req;
    logic        win_m1;
    logic [31:0] win_addr;
    logic        granted_rready;

    // last_m1_q high means M1 was the most recent winner.
    always_comb begin
        any_req        = arvalid_m0 | arvalid_m1;
        win_m1         = (arvalid_m0 & arvalid_m1) ? ~last_m1_q : arvalid_m1;
        win_addr       = win_m1 ? araddr_m1 : araddr_m0;
        granted_rready = (grant_q[0] & rready_m0) | (grant_q[1] & rready_m1);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        last_m1_d     = last_m1_q;
        arready_m0    = 1'b0;
        arready_m1    = 1'b0;
        arvalid_s0_en = 1'b0;
        arvalid_s1_en = 1'b0;
        def_rvalid    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d   = StAddr;
                    grant_d   = win_m1 ? GrantM1 : GrantM0;
                    sel_d     = decode_addr(win_addr);
                    last_m1_d = win_m1;
                end
            end

            StAddr: begin
                unique case (sel_q)
                    SelS0: begin
                        arvalid_s0_en = 1'b1;
                        arready_m0    = grant_q[0] & arready_s0;
                        arready_m1    = grant_q[1] & arready_s0;
                        if (arready_s0) begin
                            state_d = StData;
                        end
                    end
                    SelS1: begin
                        arvalid_s1_en = 1'b1;
                        arready_m0    = grant_q[0] & arready_s1;
                        arready_m1    = grant_q[1] & arready_s1;
                        if (arready_s1) begin
                            state_d = StData;
                        end
                    end
                    SelDef: begin
                        arready_m0 = grant_q[0];
                        arready_m1 = grant_q[1];
                        state_d    = StDef;
                    end
                    default: begin
                        // Unreachable selection; fall back to idle rather than lock up.
                        state_d = StIdle;
                        grant_d = GrantNone;
                        sel_d   = SelNone;
                    end
                endcase
            end

            StData: begin
                if (rlast_hs) begin
                    state_d = StIdle;
                    grant_d = GrantNone;
                    sel_d   = SelNone;
                end
            end

            StDef: begin
                def_rvalid = 1'b1;
                if (granted_rready) begin
                    state_d = StIdle;
                    grant_d = GrantNone;
                    sel_d   = SelNone;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = GrantNone;
                sel_d   = SelNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= GrantNone;
            sel_q     <= SelNone;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_m1_q <= last_m1_d;
        end
    end

    assign grant     = grant_q;
    assign slave_sel = sel_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin owner, address-range decode).
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid_m0, arvalid_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic        arready_s0, arready_s1;
    logic        rlast_hs;
    logic        rready_m0, rready_m1;
    logic        arready_m0, arready_m1;
    logic        arvalid_s0_en, arvalid_s1_en;
    logic [1:0]  grant;
    logic [1:0]  slave_sel;
    logic        def_rvalid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic last_m = 1'b1;   // model: most recent winner (1 = M1)
    bit   chained = 1'b0;  // loser's request already pending in the current idle cycle
    logic pend_loser;

    always #5 clk = ~clk;

    axi_read_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .arvalid_m0    (arvalid_m0),
        .arvalid_m1    (arvalid_m1),
        .araddr_m0     (araddr_m0),
        .araddr_m1     (araddr_m1),
        .arready_s0    (arready_s0),
        .arready_s1    (arready_s1),
        .rlast_hs      (rlast_hs),
        .rready_m0     (rready_m0),
        .rready_m1     (rready_m1),
        .arready_m0    (arready_m0),
        .arready_m1    (arready_m1),
        .arvalid_s0_en (arvalid_s0_en),
        .arvalid_s1_en (arvalid_s1_en),
        .grant         (grant),
        .slave_sel     (slave_sel),
        .def_rvalid    (def_rvalid),
        .busy          (busy)
    );

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [1:0] decode(input logic [31:0] a);
        if (a < 32'h0001_0000) return 2'd0;
        if (a < 32'h0002_0000) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] bnd [5];
        bnd = '{32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000, 32'hFFFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return {16'h0000, 16'($urandom)};
            1:       return {16'h0001, 16'($urandom)};
            2:       return {16'($urandom_range(2, 65535)), 16'($urandom)};
            default: return bnd[$urandom_range(0, 4)];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] g, input logic [1:0] s,
                             input logic a0, input logic a1, input logic e0, input logic e1,
                             input logic d, input logic b);
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".slave_sel"}, slave_sel, s);
        chk({tag, ".arready_m0"}, {1'b0, arready_m0}, {1'b0, a0});
        chk({tag, ".arready_m1"}, {1'b0, arready_m1}, {1'b0, a1});
        chk({tag, ".arvalid_s0_en"}, {1'b0, arvalid_s0_en}, {1'b0, e0});
        chk({tag, ".arvalid_s1_en"}, {1'b0, arvalid_s1_en}, {1'b0, e1});
        chk({tag, ".def_rvalid"}, {1'b0, def_rvalid}, {1'b0, d});
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, b});
    endtask

    task automatic check_idle(input string tag);
        check_out(tag, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_inputs();
        arvalid_m0 = 1'b0;
        arvalid_m1 = 1'b0;
        arready_s0 = 1'b0;
        arready_s1 = 1'b0;
        rlast_hs   = 1'b0;
        rready_m0  = 1'b0;
        rready_m1  = 1'b0;
    endtask

    // Reset with junk on the inputs; nothing may be accepted while rst is high.
    task automatic do_reset();
        @(posedge clk); #1;
        rst        = 1'b1;
        arvalid_m0 = rbit();
        arvalid_m1 = rbit();
        araddr_m0  = rand_addr();
        araddr_m1  = rand_addr();
        rlast_hs   = rbit();
        rready_m0  = rbit();
        rready_m1  = rbit();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_idle("after_reset");
        last_m  = 1'b1;
        chained = 1'b0;
    endtask

    // One full read by model-predicted winner; hold keeps the loser requesting into idle.
    task automatic run_txn(input logic r0, input logic r1, input logic [31:0] a0,
                           input logic [31:0] a1, input int ar_dly, input int r_dly,
                           input bit hold);
        logic       w;
        logic [1:0] g;
        logic [1:0] sel;
        logic       rdy;
        logic       done;
        w = (r0 && r1) ? ~last_m : r1;
        last_m = w;
        g   = w ? 2'b10 : 2'b01;
        sel = decode(w ? a1 : a0);
        pend_loser = ~w;

        if (!chained) begin
            @(posedge clk); #1;
            arvalid_m0 = r0;
            arvalid_m1 = r1;
            araddr_m0  = a0;
            araddr_m1  = a1;
            @(negedge clk);
            check_idle("idle_req");
        end
        chained = 1'b0;

        if (sel == 2'd2) begin
            @(posedge clk); #1;
            arready_s0 = rbit();
            arready_s1 = rbit();
            rlast_hs   = rbit();
            @(negedge clk);
            check_out("addr_def", g, 2'd2, ~w, w, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i <= ar_dly; i++) begin
                @(posedge clk); #1;
                rdy = (i == ar_dly);
                if (sel == 2'd0) begin
                    arready_s0 = rdy;
                    arready_s1 = rbit();
                end else begin
                    arready_s1 = rdy;
                    arready_s0 = rbit();
                end
                rlast_hs  = rbit();
                rready_m0 = rbit();
                rready_m1 = rbit();
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    if (w) arvalid_m1 = 1'b0;
                    else arvalid_m0 = 1'b0;
                end
                @(negedge clk);
                check_out("addr", g, sel, ~w & rdy, w & rdy, sel == 2'd0, sel == 2'd1, 1'b0,
                          1'b1);
            end
        end

        for (int i = 0; i <= r_dly; i++) begin
            @(posedge clk); #1;
            done       = (i == r_dly);
            arready_s0 = rbit();
            arready_s1 = rbit();
            if (w) arvalid_m1 = 1'b0;
            else arvalid_m0 = 1'b0;
            if (sel == 2'd2) begin
                rlast_hs  = rbit();
                rready_m0 = w ? rbit() : done;
                rready_m1 = w ? done : rbit();
            end else begin
                rlast_hs  = done;
                rready_m0 = rbit();
                rready_m1 = rbit();
            end
            @(negedge clk);
            check_out(sel == 2'd2 ? "def" : "data", g, sel, 1'b0, 1'b0, 1'b0, 1'b0,
                      sel == 2'd2, 1'b1);
        end

        @(posedge clk); #1;
        arready_s0 = 1'b0;
        arready_s1 = 1'b0;
        rlast_hs   = 1'b0;
        rready_m0  = 1'b0;
        rready_m1  = 1'b0;
        if (!hold) begin
            arvalid_m0 = 1'b0;
            arvalid_m1 = 1'b0;
        end
        @(negedge clk);
        check_idle("txn_end");
        if (hold) chained = 1'b1;
    endtask

    // M0 alone takes the bus, then rst is pulsed once it sits in DATA or DEF.
    task automatic mid_reset(input logic [31:0] addr);
        logic [1:0] sel;
        sel = decode(addr);
        @(posedge clk); #1;
        arvalid_m0 = 1'b1;
        arvalid_m1 = 1'b0;
        araddr_m0  = addr;
        @(negedge clk);
        check_idle("mr_idle");
        @(posedge clk); #1;
        arready_s0 = 1'b1;
        @(negedge clk);
        check_out("mr_addr", 2'b01, sel, 1'b1, 1'b0, sel == 2'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        arready_s0 = 1'b0;
        arvalid_m0 = 1'b0;
        @(negedge clk);
        check_out("mr_phase", 2'b01, sel, 1'b0, 1'b0, 1'b0, 1'b0, sel == 2'd2, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("mr_after_rst");
        last_m  = 1'b1;
        chained = 1'b0;
    endtask

    initial begin
        logic       r0, r1, hold;
        logic [31:0] a0, a1;
        rst       = 1'b1;
        araddr_m0 = 32'h0;
        araddr_m1 = 32'h0;
        clear_inputs();
        do_reset();

        // Simultaneous requests after reset: M0 first, then M1.
        run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0010, 0, 0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0010, 1, 1, 1'b0);
        // M1 alone to S1 with three stalled AR cycles.
        run_txn(1'b0, 1'b1, 32'h0, 32'h0001_0000, 3, 0, 1'b0);
        // Unmapped address from M0, two cycles of rready_m0 low.
        run_txn(1'b1, 1'b0, 32'h0002_0000, 32'h0, 0, 2, 1'b0);
        // Loser stays requesting through the winner's read and is granted right after.
        run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0001_0004, 0, 3, 1'b1);
        run_txn(~pend_loser, pend_loser, 32'h0000_0200, 32'h0001_0004, 0, 1, 1'b0);
        // Reset mid-read restores M1 as last winner, so M0 wins next.
        mid_reset(32'h0000_0100);
        run_txn(1'b1, 1'b1, 32'h0001_8000, 32'h0000_0040, 0, 0, 1'b0);
        mid_reset(32'h0003_0000);
        run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0040, 0, 0, 1'b0);
        // Decode edges.
        run_txn(1'b1, 1'b0, 32'h0000_FFFF, 32'h0, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h0001_FFFF, 0, 0, 1'b0);

        hold = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (chained) begin
                r0 = ~pend_loser;
                r1 = pend_loser;
                a0 = araddr_m0;
                a1 = araddr_m1;
                hold = 1'b0;
            end else begin
                r0 = rbit();
                r1 = rbit();
                if (!r0 && !r1) r0 = 1'b1;
                a0 = rand_addr();
                a1 = rand_addr();
                hold = r0 & r1 & rbit();
            end
            run_txn(r0, r1, a0, a1, $urandom_range(0, 3), $urandom_range(0, 3), hold);
        end
        if (chained) begin
            run_txn(~pend_loser, pend_loser, araddr_m0, araddr_m1, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
